sc_stream_sequencer: RTL and testbench

//  Converts one signed QUANT-bit sample into a BITSTREAM-long stochastic bitstream.
//  The stream carries exactly quota ones and is emitted one bit per handshake.

---
 rtl/sc_stream_sequencer.sv | 107 ++++++++++
 tb/tb_sc_stream_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sc_stream_sequencer.sv
// Turns one signed sample into a BITSTREAM-long stochastic stream with exactly quota ones.
// Ones are spread low-discrepancy by comparing a bit-reversed counter against quota.
module sc_stream_sequencer #(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [QUANT-1:0]           in_data,
  input  logic                       flush,
  output logic                       bit_valid,
  input  logic                       bit_ready,
  output logic                       out_bit,
  output logic                       bit_last,
  output logic                       done,
  output logic [$clog2(BITSTREAM):0] ones_cnt
);
  localparam int Q = $clog2(BITSTREAM);
  localparam int D = QUANT - Q;
  localparam logic [QUANT:0] RND_ADD = (D > 0) ? ((QUANT+1)'(1) << ((D > 0) ? D - 1 : 0)) : '0;

  if (BITSTREAM != (1 << Q)) begin : g_chk_pow2
    $error("sc_stream_sequencer: BITSTREAM must be a power of two");
  end
  if (QUANT < Q) begin : g_chk_quant
    $error("sc_stream_sequencer: QUANT must be >= $clog2(BITSTREAM)");
  end

  typedef enum logic {IDLE, STREAM} state_t;

  state_t         state, state_nxt;
  logic [Q:0]     quota_q, quota_in, ones;
  logic [Q-1:0]   cnt;
  logic [QUANT:0] bias, rnd;
  logic           cmp_bit, hs;

  function automatic logic [Q-1:0] bitrev(input logic [Q-1:0] v);
    logic [Q-1:0] r;
    for (int i = 0; i < Q; i++) r[i] = v[Q-1-i];
    return r;
  endfunction

  // Offset-binary bias is the sign-bit flip; the extra MSB leaves room for the rounding carry.
  assign bias     = {1'b0, ~in_data[QUANT-1], in_data[QUANT-2:0]};
  assign rnd      = bias + RND_ADD;
  assign quota_in = (Q+1)'(rnd >> D);
  assign cmp_bit  = ({1'b0, bitrev(cnt)} < quota_q);
  assign hs       = bit_valid && bit_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = STREAM;
      STREAM:  if (flush || (hs && bit_last)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    bit_valid = 1'b0;
    out_bit   = 1'b0;
    bit_last  = 1'b0;
    case (state)
      IDLE:   in_ready = 1'b1;
      STREAM: begin
        bit_valid = 1'b1;
        out_bit   = cmp_bit;
        bit_last  = &cnt;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // cnt wraps to zero on the final handshake, which is harmless since the stream ends there.
  always_ff @(posedge clk) begin
    if (rst) begin
      quota_q  <= '0;
      cnt      <= '0;
      ones     <= '0;
      done     <= 1'b0;
      ones_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && in_valid) begin
        quota_q <= quota_in;
        cnt     <= '0;
        ones    <= '0;
      end else if (state == STREAM && !flush && hs) begin
        cnt  <= cnt + 1'b1;
        ones <= ones + {{Q{1'b0}}, out_bit};
        if (bit_last) begin
          done     <= 1'b1;
          ones_cnt <= ones + {{Q{1'b0}}, out_bit};
        end
      end
    end
  end

endmodule

// File: tb/tb_sc_stream_sequencer.sv
// Directed bench for sc_stream_sequencer: table of samples with hand-computed streams,
// plus stall, flush and mid-stream reset sequences.
module tb_sc_stream_sequencer;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, flush;
  logic       bit_valid, bit_ready, out_bit, bit_last, done;
  logic [7:0] in_data;
  logic [6:0] ones_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  data;
    logic [63:0] bits;
    int          ones;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  sc_stream_sequencer #(.BITSTREAM(64), .QUANT(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .bit_valid(bit_valid), .bit_ready(bit_ready), .out_bit(out_bit),
    .bit_last(bit_last), .done(done), .ones_cnt(ones_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [7:0] d, input logic fl);
    @(negedge clk);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check("bit_valid_latency", 64'(bit_valid), 64'd1);
  endtask

  task automatic consume(input bit stall, output logic [63:0] bits, output int nbits,
                         output int ndone, output int bad_last, output int unstable);
    logic prev_bit, prev_last, have_prev, rdy;
    bits = '0; nbits = 0; ndone = 0; bad_last = 0; unstable = 0; have_prev = 1'b0;
    prev_bit = 1'b0; prev_last = 1'b0;
    for (int cyc = 0; cyc < 1000 && nbits < 64; cyc++) begin
      if (done) ndone++;
      if (bit_valid) begin
        if (have_prev && (out_bit !== prev_bit || bit_last !== prev_last)) unstable++;
        rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        bit_ready = rdy;
        if (rdy) begin
          bits[nbits] = out_bit;
          if (bit_last !== (nbits == 63)) bad_last++;
          nbits++;
          have_prev = 1'b0;
        end else begin
          prev_bit  = out_bit;
          prev_last = bit_last;
          have_prev = 1'b1;
        end
      end else begin
        bit_ready = 1'b0;
      end
      @(negedge clk);
    end
    bit_ready = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [7:0] d, input logic fl,
                               input bit stall, input logic [63:0] exp_bits, input int exp_ones);
    logic [63:0] bits;
    int nbits, ndone, bad_last, unstable, extra;
    accept(d, fl);
    consume(stall, bits, nbits, ndone, bad_last, unstable);
    check({tag, "_bits_seen"}, 64'(nbits), 64'd64);
    check({tag, "_bits"}, bits, exp_bits);
    check({tag, "_early_done"}, 64'(ndone), 64'd0);
    check({tag, "_bit_last"}, 64'(bad_last), 64'd0);
    check({tag, "_stall_stable"}, 64'(unstable), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_ones_cnt"}, 64'(ones_cnt), 64'(exp_ones));
    check({tag, "_in_ready_at_done"}, 64'(in_ready), 64'd1);
    check({tag, "_bit_valid_at_done"}, 64'(bit_valid), 64'd0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, "_single_done"}, 64'(extra), 64'd0);
    check({tag, "_ones_cnt_held"}, 64'(ones_cnt), 64'(exp_ones));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; bit_ready = 1'b0;

    vecs[0] = '{data: 8'h80, bits: 64'h0000_0000_0000_0000, ones: 0};
    vecs[1] = '{data: 8'h7f, bits: 64'hFFFF_FFFF_FFFF_FFFF, ones: 64};
    vecs[2] = '{data: 8'h00, bits: 64'h5555_5555_5555_5555, ones: 32};
    vecs[3] = '{data: 8'h01, bits: 64'h5555_5555_5555_5555, ones: 32};
    vecs[4] = '{data: 8'h02, bits: 64'h5555_5555_5555_5557, ones: 33};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_bit_valid", 64'(bit_valid), 64'd0);
    check("rst_out_bit", 64'(out_bit), 64'd0);
    check("rst_bit_last", 64'(bit_last), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ones_cnt", 64'(ones_cnt), 64'd0);

    for (int i = 0; i < 5; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].data, 1'b0, 1'b0, vecs[i].bits, vecs[i].ones);

    // quota 48: bitrev(cnt) < 48 fails only when cnt[1:0] == 3
    run_and_check("stall", 8'h40, 1'b0, 1'b1, 64'h7777_7777_7777_7777, 48);

    // Flush at cnt=10 with a simultaneous handshake
    accept(8'h00, 1'b0);
    bit_ready = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bit_ready = 1'b0;
    check("flush_bit_valid", 64'(bit_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_no_done", 64'(done), 64'd0);
    check("flush_ones_cnt", 64'(ones_cnt), 64'd48);
    @(negedge clk);
    check("flush_no_done_later", 64'(done), 64'd0);
    run_and_check("after_flush", 8'h02, 1'b1, 1'b0, 64'h5555_5555_5555_5557, 33);

    // Reset at cnt=20
    accept(8'h40, 1'b0);
    bit_ready = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bit_ready = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_bit_valid", 64'(bit_valid), 64'd0);
    check("midrst_out_bit", 64'(out_bit), 64'd0);
    check("midrst_bit_last", 64'(bit_last), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_ones_cnt", 64'(ones_cnt), 64'd0);
    run_and_check("after_rst", 8'h80, 1'b0, 1'b0, 64'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
